// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_e : receiver FSM states (PARITY is used only when
//                    UART_RCVR_PARITY_EN is defined)
//   - START_LVL / STOP_LVL / IDLE_LVL : serial line levels of a frame
//   - DEF_WORD_SIZE / DEF_CLKS_PER_BIT : default frame geometry
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    localparam int DEF_WORD_SIZE    = 8;
    localparam int DEF_CLKS_PER_BIT = 8;

endpackage

// File: rtl/uart_rcvr_if.sv
// uart_rcvr_if: bus-side handshake between the UART receiver and its reader.
//   RCV_datareg  last good received byte
//   Data_ready   RCV_datareg holds an unread byte
//   Read_ack     one-cycle pulse from the reader: byte consumed, flags cleared
//   Frame_err    sticky, stop bit sampled low
//   Overrun_err  sticky, frame completed while Data_ready was set
//   Parity_err   sticky, even-parity mismatch (only with UART_RCVR_PARITY_EN)
//   Busy         receiver is not idle
// Modports: slave = receiver, master = bus-side reader.
interface uart_rcvr_if
    import uart_pkg::*;
#(
    parameter int WordSize = DEF_WORD_SIZE
);
    logic [WordSize-1:0] RCV_datareg;
    logic                Data_ready;
    logic                Read_ack;
    logic                Frame_err;
    logic                Overrun_err;
    logic                Busy;
`ifdef UART_RCVR_PARITY_EN
    logic                Parity_err;

    modport slave  (input  Read_ack,
                    output RCV_datareg, Data_ready, Frame_err, Overrun_err, Busy, Parity_err);
    modport master (output Read_ack,
                    input  RCV_datareg, Data_ready, Frame_err, Overrun_err, Busy, Parity_err);
`else
    modport slave  (input  Read_ack,
                    output RCV_datareg, Data_ready, Frame_err, Overrun_err, Busy);
    modport master (output Read_ack,
                    input  RCV_datareg, Data_ready, Frame_err, Overrun_err, Busy);
`endif
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running sample counter for one serial bit period.
//   clk, Reset   clock and synchronous active-high reset
//   clear_i      restart the count at 0 on the next edge
//   half_tick_o  high in the cycle the count reaches ClksPerBit/2
//   full_tick_o  high in the cycle the count reaches ClksPerBit; the
//                counter wraps there so consecutive bits need no clear
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int ClksPerBit = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear_i,
    output logic half_tick_o,
    output logic full_tick_o
);
    localparam int CW = $clog2(ClksPerBit);
    localparam logic [CW-1:0] HALF_LAST = CW'(ClksPerBit / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(ClksPerBit - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == FULL_LAST)) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign half_tick_o = (cnt_q == HALF_LAST);
    assign full_tick_o = (cnt_q == FULL_LAST);

endmodule

// File: rtl/uart_rcvr.sv
// uart_rcvr: oversampling UART receiver with ready/acknowledge hand-off.
//   clk        system clock
//   Reset      synchronous active-high reset, aborts any frame in progress
//   Serial_in  asynchronous serial line, idles high, LSB first
//   bus        uart_rcvr_if.slave (RCV_datareg, Data_ready, Read_ack,
//              Frame_err, Overrun_err, Busy [, Parity_err])
// Optional feature macro: UART_RCVR_PARITY_EN adds one even-parity bit
// between the data bits and the stop bit, plus the sticky Parity_err flag.
// Frame: start, WordSize data bits, [parity], stop.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int WordSize   = DEF_WORD_SIZE,
    parameter int ClksPerBit = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Serial_in,
    uart_rcvr_if.slave bus
);
    localparam int BW = (WordSize > 1) ? $clog2(WordSize) : 1;

    // synchronizer, preset to the idle level so reset never looks like a start
    logic sync1_q, rx_s_q;

    uart_state_e         state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WordSize-1:0] shift_q, shift_d;
    logic                load_pend_q, load_pend_d;
    logic [WordSize-1:0] datareg_q, datareg_d;
    logic                ready_q, ready_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                frame_err_set;
    logic                load_ok;
    logic                half_tick, full_tick, tmr_clear;
`ifdef UART_RCVR_PARITY_EN
    logic                par_bit_q, par_bit_d;
    logic                perr_q, perr_d;
    logic                par_err_set;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q <= IDLE_LVL;
            rx_s_q  <= IDLE_LVL;
        end else begin
            sync1_q <= Serial_in;
            rx_s_q  <= sync1_q;
        end
    end

    // Hold the timer at 0 while waiting for an edge and restart it on every
    // state change, so START counts from the detected falling edge and each
    // later sample lands mid-bit.
    assign tmr_clear = (state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_IDLE);

    uart_bit_timer #(.ClksPerBit(ClksPerBit)) u_timer (
        .clk         (clk),
        .Reset       (Reset),
        .clear_i     (tmr_clear),
        .half_tick_o (half_tick),
        .full_tick_o (full_tick)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        load_pend_d   = 1'b0;
        frame_err_set = 1'b0;
`ifdef UART_RCVR_PARITY_EN
        par_bit_d     = par_bit_q;
        par_err_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx_s_q == START_LVL) state_d = START;
            end
            START: begin
                if (half_tick) begin
                    if (rx_s_q == START_LVL) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;  // glitch shorter than half a bit
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    shift_d   = {rx_s_q, shift_q[WordSize-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(WordSize - 1)) begin
`ifdef UART_RCVR_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RCVR_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    par_bit_d = rx_s_q;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    if (rx_s_q == STOP_LVL) begin
                        state_d = IDLE;
`ifdef UART_RCVR_PARITY_EN
                        if ((^shift_q) != par_bit_q) par_err_set = 1'b1;
                        else                         load_pend_d = 1'b1;
`else
                        load_pend_d = 1'b1;
`endif
                    end else begin
                        // hold off until the line idles so a break is one error
                        frame_err_set = 1'b1;
                        state_d       = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q == IDLE_LVL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hand-off happens the cycle after the stop sample; an ack in that same
    // cycle frees the register, so the new byte replaces the acked one.
    always_comb begin
        datareg_d = datareg_q;
        ready_d   = ready_q;
        load_ok   = load_pend_q && (!ready_q || bus.Read_ack);
        if (load_ok) begin
            datareg_d = shift_q;
            ready_d   = 1'b1;
        end else if (bus.Read_ack) begin
            ready_d = 1'b0;
        end
        ferr_d = (ferr_q && !bus.Read_ack) || frame_err_set;
        ovr_d  = (ovr_q && !bus.Read_ack) || (load_pend_q && !load_ok);
`ifdef UART_RCVR_PARITY_EN
        perr_d = (perr_q && !bus.Read_ack) || par_err_set;
`endif
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            load_pend_q <= 1'b0;
            datareg_q   <= '0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
            par_bit_q   <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            load_pend_q <= load_pend_d;
            datareg_q   <= datareg_d;
            ready_q     <= ready_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
`ifdef UART_RCVR_PARITY_EN
            par_bit_q   <= par_bit_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign bus.RCV_datareg = datareg_q;
    assign bus.Data_ready  = ready_q;
    assign bus.Frame_err   = ferr_q;
    assign bus.Overrun_err = ovr_q;
    assign bus.Busy        = (state_q != IDLE);
`ifdef UART_RCVR_PARITY_EN
    assign bus.Parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rcvr.sv
// tb_uart_rcvr: randomized + directed bench for uart_rcvr. The stimulus
// process keeps a frame-level model of what the receiver should deliver and
// queues expected bytes; a monitor process checks each byte hand-off
// (value and latency) and acknowledges it. With UART_RCVR_PARITY_EN the
// frames carry an even-parity bit.
module tb_uart_rcvr;
    localparam int W   = 8;
    localparam int CPB = 8;
`ifdef UART_RCVR_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB  = W + 2 + PB;                          // bits per frame
    localparam int LAT = 2 + CPB / 2 + (W + 1 + PB) * CPB + 1;

    typedef struct {
        logic [W-1:0] b;
        int           start;
    } exp_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic Serial_in = 1'b1;
    int   cyc = 0;

    uart_rcvr_if #(.WordSize(W)) bus ();

    uart_rcvr #(.WordSize(W), .ClksPerBit(CPB)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Serial_in (Serial_in),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    bit   auto_ack = 1'b1;
    int   ack_reqs = 0;
    int   ack_done = 0;

    // model of the bus-visible flags
    bit m_ready = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ready"}, int'(bus.Data_ready), int'(m_ready));
        chk({tag, "_ferr"}, int'(bus.Frame_err), int'(m_ferr));
        chk({tag, "_ovr"}, int'(bus.Overrun_err), int'(m_ovr));
`ifdef UART_RCVR_PARITY_EN
        chk({tag, "_perr"}, int'(bus.Parity_err), int'(m_perr));
`endif
    endtask

    task automatic do_ack();
        ack_reqs++;
        m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        idle(3);
    endtask

    // Drive one frame starting at the current negedge. stop_low > 0 holds the
    // stop bit low for that many bit times before releasing the line.
    task automatic send_frame(input logic [W-1:0] b, input int stop_low, input bit par_flip);
        if (stop_low > 0) m_ferr = 1'b1;
        else if (PB == 1 && par_flip) m_perr = 1'b1;
        else if (m_ready) m_ovr = 1'b1;
        else begin
            exp_q.push_back('{b: b, start: cyc + 1});
            if (auto_ack) begin
                m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;  // the ack clears them
            end else begin
                m_ready = 1'b1;
            end
        end
        Serial_in = 1'b0;
        idle(CPB);
        for (int i = 0; i < W; i++) begin
            Serial_in = b[i];
            idle(CPB);
        end
        if (PB == 1) begin
            Serial_in = (^b) ^ par_flip;
            idle(CPB);
        end
        if (stop_low > 0) begin
            Serial_in = 1'b0;
            idle(CPB * stop_low);
        end
        Serial_in = 1'b1;
        idle(CPB);
    endtask

    // monitor: every rising Data_ready is one byte hand-off
    initial begin : monitor
        bit   prev_dr;
        exp_t e;
        prev_dr = 1'b0;
        bus.Read_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.Read_ack = 1'b0;
            if (bus.Data_ready && !prev_dr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", int'(bus.RCV_datareg), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_byte", int'(bus.RCV_datareg), int'(e.b));
                    chk("rx_latency", cyc - e.start, LAT);
                end
                if (auto_ack) bus.Read_ack = 1'b1;
            end
            if (ack_reqs != ack_done) begin
                bus.Read_ack = 1'b1;
                ack_done++;
            end
            prev_dr = bus.Data_ready;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [W-1:0] rb;
        int           t;
        // reset state
        idle(3);
        Reset = 1'b0;
        idle(2);
        chk("rst_datareg", int'(bus.RCV_datareg), 0);
        chk("rst_busy", int'(bus.Busy), 0);
        chk_flags("rst");

        // single frame, latency checked by the monitor
        send_frame(8'h35, 0, 1'b0);
        idle(CPB);
        chk("f35_datareg", int'(bus.RCV_datareg), 8'h35);
        chk_flags("f35");

        // back-to-back frames, acked between
        send_frame(8'hA5, 0, 1'b0);
        send_frame(8'h3C, 0, 1'b0);
        idle(CPB);
        chk("b2b_datareg", int'(bus.RCV_datareg), 8'h3C);
        chk_flags("b2b");

        // overrun: second frame while first unread
        auto_ack = 1'b0;
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h22, 0, 1'b0);
        idle(CPB);
        chk("ovr_datareg", int'(bus.RCV_datareg), 8'h11);
        chk_flags("ovr");
        do_ack();
        chk_flags("ovr_ack");
        auto_ack = 1'b1;

        // break: stop held low 3 bit times
        fork
            send_frame(8'h5A, 3, 1'b0);
            begin
                idle((FB + 1) * CPB + 1);
                chk("brk_busy_low", int'(bus.Busy), 1);
                chk("brk_ferr_low", int'(bus.Frame_err), 1);
            end
        join
        idle(2);
        chk("brk_busy_rel", int'(bus.Busy), 0);
        chk_flags("brk");
        send_frame(8'h01, 0, 1'b0);
        idle(CPB);
        chk("brk_next_datareg", int'(bus.RCV_datareg), 8'h01);
        chk_flags("brk_next");

        // 2-clock glitch on the idle line
        Serial_in = 1'b0;
        idle(2);
        Serial_in = 1'b1;
        idle(3 * CPB);
        chk("glitch_busy", int'(bus.Busy), 0);
        chk_flags("glitch");

        // reset mid-DATA with a byte pending
        auto_ack = 1'b0;
        send_frame(8'h7E, 0, 1'b0);
        idle(2);
        chk("pre_rst_datareg", int'(bus.RCV_datareg), 8'h7E);
        Serial_in = 1'b0;
        idle(CPB);
        Serial_in = 1'b1;
        idle(3 * CPB);
        chk("pre_rst_busy", int'(bus.Busy), 1);
        Reset = 1'b1;
        idle(1);
        m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        chk("mid_rst_datareg", int'(bus.RCV_datareg), 0);
        chk("mid_rst_busy", int'(bus.Busy), 0);
        chk_flags("mid_rst");
        Reset = 1'b0;
        auto_ack = 1'b1;
        idle(2 * CPB);

`ifdef UART_RCVR_PARITY_EN
        send_frame(8'h35, 0, 1'b0);
        idle(CPB);
        chk_flags("par_ok");
        send_frame(8'h35, 0, 1'b1);
        idle(CPB);
        chk("par_bad_datareg", int'(bus.RCV_datareg), 8'h35);
        chk_flags("par_bad");
        do_ack();
        chk_flags("par_ack");
`endif

        // randomized frames, gaps and framing errors
        for (int i = 0; i < 24; i++) begin
            rb = W'($urandom);
            t  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            idle(t);
            if ($urandom_range(0, 5) == 0) begin
                send_frame(rb, $urandom_range(1, 2), 1'b0);
                idle(2);
                chk_flags("rnd_ferr");
                do_ack();
                chk_flags("rnd_ack");
            end else begin
                send_frame(rb, 0, 1'b0);
            end
        end
        idle(CPB);
        chk_flags("rnd_end");

        // drain the scoreboard with a bounded wait
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            idle(1);
            t++;
        end
        chk("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
